bit_wise_inverter_8b: RTL and testbench

- Conditional bitwise inverter: when enable is high the output is the bitwise complement of the input; when low the input passes through unchanged.
- One registered pipeline stage with a valid/ready handshake, used as a data-path stage in the 8-bit CPU ALU/operand path.
- Default width 8 bits.

---
 rtl/bit_wise_inverter_8b.sv | 55 +++++
 tb/tb_bit_wise_inverter_8b.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_wise_inverter_8b.sv
// Single-stage registered conditional inverter with valid/ready handshake.
// Define BWI_PARITY_EN to add a registered out_parity (XOR of the loaded result).
module bit_wise_inverter_8b #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a,
    input  logic             input_enable,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] output_z,
    output logic             out_valid,
`ifdef BWI_PARITY_EN
    output logic             out_parity,
`endif
    input  logic             out_ready
);

    logic [WIDTH-1:0] result;
    logic             in_fire;
    logic             out_fire;

    // The stage can take new data when empty or when its current result drains this edge.
    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        result = input_enable ? ~input_a : input_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_z  <= '0;
            out_valid <= 1'b0;
        end else if (in_fire) begin
            output_z  <= result;
            out_valid <= 1'b1;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BWI_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_parity <= 1'b0;
        end else if (in_fire) begin
            out_parity <= ^result;
        end
    end
`endif

endmodule

// File: tb/tb_bit_wise_inverter_8b.sv
// Self-checking bench for bit_wise_inverter_8b: directed scenarios plus a randomized
// scoreboard run; parity checks are included when BWI_PARITY_EN is defined.
module tb_bit_wise_inverter_8b;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] input_a;
    logic             input_enable;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] output_z;
    logic             out_valid;
    logic             out_ready;
`ifdef BWI_PARITY_EN
    logic             out_parity;
`endif

    int errors = 0;
    int checks = 0;

    bit_wise_inverter_8b #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_enable (input_enable),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .output_z     (output_z),
        .out_valid    (out_valid),
`ifdef BWI_PARITY_EN
        .out_parity   (out_parity),
`endif
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, input logic e, input logic v, input logic r);
        input_a      = a;
        input_enable = e;
        in_valid     = v;
        out_ready    = r;
    endtask

    task automatic test_reset();
        // Initial reset already applied; check idle state.
        checks++;
        if (output_z !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_initial: z=%h valid=%b ready=%b, want z=00 valid=0 ready=1",
                     output_z, out_valid, in_ready);
        end
        drive(8'h5C, 1'b0, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (output_z !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: z=%h valid=%b ready=%b, want z=00 valid=0 ready=1",
                     output_z, out_valid, in_ready);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_truth_sweep();
        logic [WIDTH-1:0] a_tab [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        logic             e_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [WIDTH-1:0] z_tab [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(a_tab[i], e_tab[i], 1'b1, 1'b1);
            step();
            checks++;
            if (output_z !== z_tab[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL truth_%0d: z=%h valid=%b, want z=%h valid=1",
                         i, output_z, out_valid, z_tab[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        drive(8'hA5, 1'b1, 1'b1, 1'b1);
        step();
        checks++;
        if (output_z !== 8'h5A || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: z=%h valid=%b, want z=5a valid=1", output_z, out_valid);
        end
        drive(8'h3C, 1'b0, 1'b1, 1'b1);
        step();
        checks++;
        if (output_z !== 8'h3C || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: z=%h valid=%b, want z=3c valid=1", output_z, out_valid);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (output_z !== 8'h3C || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: z=%h valid=%b, want z=3c valid=0", output_z, out_valid);
        end
    endtask

    task automatic test_backpressure();
        drive(8'h0F, 1'b1, 1'b1, 1'b1);
        step();
        drive(8'h11, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready_%0d: in_ready=%b, want 0", i, in_ready);
            end
            step();
            checks++;
            if (output_z !== 8'hF0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold_%0d: z=%h valid=%b, want z=f0 valid=1",
                         i, output_z, out_valid);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: in_ready=%b, want 1", in_ready);
        end
        step();
        checks++;
        if (output_z !== 8'h11 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL release_load: z=%h valid=%b, want z=11 valid=1", output_z, out_valid);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_stall();
        drive(8'h0F, 1'b1, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (output_z !== 8'hF0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midstall_pre: z=%h valid=%b, want z=f0 valid=1", output_z, out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (output_z !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midstall_reset: z=%h valid=%b, want z=00 valid=0", output_z, out_valid);
        end
        #1 rst = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

`ifdef BWI_PARITY_EN
    task automatic test_parity();
        logic [WIDTH-1:0] a_tab [3] = '{8'h07, 8'h07, 8'h03};
        logic             e_tab [3] = '{1'b0, 1'b1, 1'b0};
        logic             p_tab [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(a_tab[i], e_tab[i], 1'b1, 1'b1);
            step();
            checks++;
            if (out_parity !== p_tab[i]) begin
                errors++;
                $display("FAIL parity_%0d: out_parity=%b, want %b", i, out_parity, p_tab[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask
`endif

    // Scoreboard: accepted operands queue their expected results; each output
    // transfer pops one. The stage is empty exactly when nothing is queued.
    task automatic test_random();
        logic [WIDTH-1:0] q [$];
        logic [WIDTH-1:0] exp;
        logic             want_ready;
        for (int n = 0; n < 400; n++) begin
            drive(WIDTH'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0));
            #1;
            want_ready = (q.size() == 0) || out_ready;
            checks++;
            if (in_ready !== want_ready || out_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_hs_%0d: ready=%b valid=%b, want ready=%b valid=%b",
                         n, in_ready, out_valid, want_ready, q.size() != 0);
            end
            if (q.size() != 0 && out_ready) begin
                exp = q.pop_front();
                checks++;
                if (output_z !== exp) begin
                    errors++;
                    $display("FAIL rand_data_%0d: z=%h, want %h", n, output_z, exp);
                end
`ifdef BWI_PARITY_EN
                checks++;
                if (out_parity !== ^exp) begin
                    errors++;
                    $display("FAIL rand_parity_%0d: p=%b, want %b", n, out_parity, ^exp);
                end
`endif
            end
            if (in_valid && want_ready) begin
                q.push_back(input_enable ? (input_a ^ {WIDTH{1'b1}}) : input_a);
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1;
        drive('0, 1'b0, 1'b0, 1'b1);
        #12 rst = 1'b0;
        test_reset();
        test_truth_sweep();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_stall();
`ifdef BWI_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
